// File: rtl/benes_cfg_sequencer_pkg.sv
// Shared parameters and types for the Benes network configuration sequencer.
package benes_cfg_sequencer_pkg;

    localparam int SIZE       = 8;
    localparam int SWITCH_NUM = SIZE / 2;
    localparam int STAGE_NUM  = 2 * $clog2(SIZE) - 1;
    // One pipeline register between adjacent switch stages.
    localparam int BUFFER_NUM = STAGE_NUM - 1;
    localparam int NET_LAT    = BUFFER_NUM;

    typedef enum logic [1:0] {
        EMPTY,
        RUN,
        DRAIN,
        SWAP
    } seq_state_t;

    typedef logic [SWITCH_NUM-1:0] stage_ctrl_t;

endpackage

// File: rtl/benes_cfg_bank.sv
// Shadow/active switch-control banks: the shadow is written word by word,
// and the active bank is copied from it in one cycle on swap.
module benes_cfg_bank #(
    parameter int SWITCH_NUM  = benes_cfg_sequencer_pkg::SWITCH_NUM,
    parameter int STAGE_NUM   = benes_cfg_sequencer_pkg::STAGE_NUM,
    localparam int IDX_W      = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            wr_en_i,
    input  logic [IDX_W-1:0]                wr_idx_i,
    input  logic [SWITCH_NUM-1:0]           wr_data_i,
    input  logic                            swap_i,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] sw_ctrl_o
);
    import benes_cfg_sequencer_pkg::*;

    logic [SWITCH_NUM-1:0] shadow_q [STAGE_NUM];
    logic [SWITCH_NUM-1:0] active_q [STAGE_NUM];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < STAGE_NUM; s++) begin
                shadow_q[s] <= '0;
                active_q[s] <= '0;
            end
        end else begin
            if (wr_en_i) begin
                shadow_q[wr_idx_i] <= wr_data_i;
            end
            if (swap_i) begin
                for (int unsigned s = 0; s < STAGE_NUM; s++) begin
                    active_q[s] <= shadow_q[s];
                end
            end
        end
    end

    always_comb begin
        sw_ctrl_o = '0;
        for (int unsigned s = 0; s < STAGE_NUM; s++) begin
            sw_ctrl_o[s*SWITCH_NUM +: SWITCH_NUM] = active_q[s];
        end
    end

endmodule

// File: rtl/benes_cfg_sequencer.sv
// Benes network control-plane sequencer: loads framed config words into a shadow
// bank and swaps them into the active bank only once the network has drained.
module benes_cfg_sequencer #(
    parameter int SIZE       = benes_cfg_sequencer_pkg::SIZE,
    parameter int SWITCH_NUM = SIZE / 2,
    parameter int STAGE_NUM  = 2 * $clog2(SIZE) - 1,
    parameter int NET_LAT    = STAGE_NUM - 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_valid,
    output logic                            cfg_ready,
    input  logic [SWITCH_NUM-1:0]           cfg_data,
    input  logic                            cfg_last,
    output logic                            cfg_err,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            net_in_valid,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] sw_ctrl,
    output logic                            out_valid,
    output logic                            cfg_active
);
    import benes_cfg_sequencer_pkg::*;

    localparam int WCNT_W = (STAGE_NUM > 1) ? $clog2(STAGE_NUM) : 1;
    localparam int IFL_W  = $clog2(NET_LAT + 1);
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(STAGE_NUM - 1);

    seq_state_t         state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               pending_q, pending_d;
    logic               err_q, err_d;
    logic               active_q, active_d;
    logic [IFL_W-1:0]   inflight_q, inflight_d;
    logic [NET_LAT-1:0] vld_sr_q, vld_sr_d;

    logic cfg_hs;
    logic at_last;
    logic frame_err;
    logic frame_done;
    logic swap;

    // Ready signals depend only on registered state; rst gating holds them low while in reset.
    assign cfg_ready    = !rst && !pending_q && (state_q != SWAP);
    assign net_in_valid = in_valid && in_ready;
    assign out_valid    = vld_sr_q[NET_LAT-1];
    assign cfg_err      = err_q;
    assign cfg_active   = active_q;

    assign cfg_hs     = cfg_valid && cfg_ready;
    assign at_last    = (wcnt_q == LAST_IDX);
    assign frame_err  = cfg_hs && (cfg_last != at_last);
    assign frame_done = cfg_hs && cfg_last && at_last;
    assign swap       = (state_q == SWAP);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            EMPTY: begin
                if (pending_q) state_d = SWAP;
            end
            RUN: begin
                in_ready = !rst && !pending_q;
                if (pending_q) state_d = (inflight_q == '0) ? SWAP : DRAIN;
            end
            DRAIN: begin
                if (inflight_q == '0) state_d = SWAP;
            end
            SWAP: begin
                state_d = RUN;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        wcnt_d    = wcnt_q;
        pending_d = pending_q;
        err_d     = frame_err;
        active_d  = active_q || swap;
        if (cfg_hs) begin
            wcnt_d = (frame_err || frame_done) ? '0 : wcnt_q + WCNT_W'(1);
        end
        if (swap) pending_d = 1'b0;
        if (frame_done) pending_d = 1'b1;
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({net_in_valid, out_valid})
            2'b10:   inflight_d = inflight_q + IFL_W'(1);
            2'b01:   inflight_d = inflight_q - IFL_W'(1);
            default: inflight_d = inflight_q;
        endcase
        vld_sr_d    = '0;
        vld_sr_d[0] = net_in_valid;
        for (int unsigned i = 1; i < NET_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            wcnt_q     <= '0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            active_q   <= 1'b0;
            inflight_q <= '0;
            vld_sr_q   <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            pending_q  <= pending_d;
            err_q      <= err_d;
            active_q   <= active_d;
            inflight_q <= inflight_d;
            vld_sr_q   <= vld_sr_d;
        end
    end

    benes_cfg_bank #(
        .SWITCH_NUM (SWITCH_NUM),
        .STAGE_NUM  (STAGE_NUM)
    ) u_bank (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (cfg_hs),
        .wr_idx_i  (wcnt_q),
        .wr_data_i (cfg_data),
        .swap_i    (swap),
        .sw_ctrl_o (sw_ctrl)
    );

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Directed bench for benes_cfg_sequencer; output vectors are scoreboarded
// against the configuration they were accepted under.
module tb_benes_cfg_sequencer;
    import benes_cfg_sequencer_pkg::*;

    localparam int SW_W = STAGE_NUM * SWITCH_NUM;

    logic                  clk;
    logic                  rst;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SWITCH_NUM-1:0] cfg_data;
    logic                  cfg_last;
    logic                  cfg_err;
    logic                  in_valid;
    logic                  in_ready;
    logic                  net_in_valid;
    logic [SW_W-1:0]       sw_ctrl;
    logic                  out_valid;
    logic                  cfg_active;

    int n_vec = 0;
    int n_bad = 0;
    logic [SW_W-1:0] exp_q [$];
    logic [SW_W-1:0] exp_cfg;

    benes_cfg_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_last     (cfg_last),
        .cfg_err      (cfg_err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .net_in_valid (net_in_valid),
        .sw_ctrl      (sw_ctrl),
        .out_valid    (out_valid),
        .cfg_active   (cfg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic load_frame(input logic [19:0] flat, input int nwords, input int last_at);
        logic [19:0] f;
        f = flat;
        for (int i = 0; i < nwords; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = f[i*4 +: 4];
            cfg_last  = (i == last_at);
            #1;
            check("cfg_ready_word", cfg_ready, 1);
            step();
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_data  = '0;
    endtask

    // Every vector leaving the network must carry the config it entered under.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL out_unexpected: out_valid with sw_ctrl=%h, none expected", sw_ctrl);
            end else begin
                exp_cfg = exp_q.pop_front();
                if (sw_ctrl !== exp_cfg) begin
                    n_bad++;
                    $display("FAIL out_cfg: sw_ctrl=%h expected %h (t=%0t)", sw_ctrl, exp_cfg, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; in_valid = 1'b0;
        step(); step();
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_cfg_active", cfg_active, 0);
        check("rst_sw_ctrl", sw_ctrl, 0);
        rst = 1'b0;
        #1;
        check("post_rst_cfg_ready", cfg_ready, 1);
        check("empty_in_ready", in_ready, 0);

        // Load from EMPTY
        load_frame(20'hF8421, 5, 4);
        check("t1_cfg_ready", cfg_ready, 0);
        check("t1_in_ready", in_ready, 0);
        check("t1_sw_ctrl", sw_ctrl, 0);
        step();
        check("t2_cfg_ready", cfg_ready, 0);
        check("t2_state_swap", int'(dut.state_q), int'(SWAP));
        step();
        check("t3_sw_ctrl", sw_ctrl, 32'hF8421);
        check("t3_cfg_ready", cfg_ready, 1);
        check("t3_in_ready", in_ready, 1);
        check("t3_cfg_active", cfg_active, 1);

        // Latency: three accepts, outputs four cycles later each
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            #1;
            check("lat_net_in_valid", net_in_valid, 1);
            exp_q.push_back(20'hF8421);
            step();
        end
        in_valid = 1'b0;
        for (int d = 3; d <= 7; d++) begin
            #1;
            check("lat_out_valid", out_valid, (d >= 4 && d <= 6) ? 1 : 0);
            if (d == 3) check("lat_inflight_peak", dut.inflight_q, 3);
            if (d == 7) check("lat_inflight_zero", dut.inflight_q, 0);
            step();
        end

        // Drain-before-swap with continuous streaming
        begin
            logic [19:0] f;
            f = 20'h12345;
            for (int k = 0; k <= 11; k++) begin
                in_valid  = 1'b1;
                cfg_valid = (k <= 4);
                cfg_data  = (k <= 4) ? f[k*4 +: 4] : 4'h0;
                cfg_last  = (k == 4);
                #1;
                check("drain_in_ready", in_ready, (k <= 4 || k == 11) ? 1 : 0);
                check("drain_cfg_ready", cfg_ready, (k <= 4 || k == 11) ? 1 : 0);
                check("drain_sw_ctrl", sw_ctrl, (k <= 10) ? 32'hF8421 : 32'h12345);
                if (k <= 4) exp_q.push_back(20'hF8421);
                if (k == 11) exp_q.push_back(20'h12345);
                step();
            end
        end
        in_valid = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0;
        repeat (5) step();

        // Framing error: early last on the third word
        load_frame(20'h00777, 3, 2);
        check("err1_pulse", cfg_err, 1);
        check("err1_pending", dut.pending_q, 0);
        check("err1_sw_ctrl", sw_ctrl, 32'h12345);
        step();
        check("err1_pulse_end", cfg_err, 0);
        check("err1_sw_ctrl_hold", sw_ctrl, 32'h12345);
        load_frame(20'hABCDE, 5, 4);
        check("reload_cfg_ready", cfg_ready, 0);
        step(); step();
        check("reload_sw_ctrl", sw_ctrl, 32'hABCDE);

        // Framing error: fifth word without last
        load_frame(20'h55555, 5, 99);
        check("err2_pulse", cfg_err, 1);
        check("err2_sw_ctrl", sw_ctrl, 32'hABCDE);
        step();
        check("err2_pulse_end", cfg_err, 0);
        check("err2_wcnt", dut.wcnt_q, 0);

        // Backpressure: sixth word held while pending
        load_frame(20'h13579, 5, 4);
        cfg_valid = 1'b1; cfg_data = 4'h6; cfg_last = 1'b0;
        #1;
        check("bp_t1_cfg_ready", cfg_ready, 0);
        step();
        check("bp_t2_cfg_ready", cfg_ready, 0);
        step();
        check("bp_t3_cfg_ready", cfg_ready, 1);
        check("bp_t3_sw_ctrl", sw_ctrl, 32'h13579);
        step();
        cfg_valid = 1'b0;
        check("bp_wcnt", dut.wcnt_q, 1);
        check("bp_shadow0", dut.u_bank.shadow_q[0], 4'h6);

        // Finish that frame while two vectors enter, then reset mid-drain
        for (int j = 1; j <= 4; j++) begin
            cfg_valid = 1'b1;
            cfg_data  = 4'(6 + j);
            cfg_last  = (j == 4);
            in_valid  = (j >= 3);
            #1;
            if (j >= 3) begin
                check("rd_in_ready", in_ready, 1);
                exp_q.push_back(20'h13579);
            end
            step();
        end
        cfg_valid = 1'b0; cfg_last = 1'b0; in_valid = 1'b0;
        check("rd_pending", dut.pending_q, 1);
        check("rd_inflight", dut.inflight_q, 2);
        step();
        check("rd_state_drain", int'(dut.state_q), int'(DRAIN));
        check("rd_inflight_drain", dut.inflight_q, 2);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("rd_rst_cfg_ready", cfg_ready, 0);
        check("rd_rst_in_ready", in_ready, 0);
        step();
        check("rd_sw_ctrl", sw_ctrl, 0);
        check("rd_out_valid", out_valid, 0);
        check("rd_state_empty", int'(dut.state_q), int'(EMPTY));
        check("rd_pending_clr", dut.pending_q, 0);
        check("rd_inflight_clr", dut.inflight_q, 0);
        check("rd_cfg_active", cfg_active, 0);
        check("rd_cfg_err", cfg_err, 0);
        check("rd_net_in_valid", net_in_valid, 0);
        check("rd_shadow0", dut.u_bank.shadow_q[0], 4'h0);
        step();
        check("rd_out_valid2", out_valid, 0);
        rst = 1'b0;
        #1;
        check("rd_post_cfg_ready", cfg_ready, 1);
        check("rd_post_in_ready", in_ready, 0);
        repeat (3) step();
        check("rd_late_sw_ctrl", sw_ctrl, 0);
        check("rd_late_state", int'(dut.state_q), int'(EMPTY));
        check("rd_late_cfg_active", cfg_active, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
